// File: rtl/mix_columns_serial_if.sv
// Handshake bundle for the serial MixColumns unit: input state valid/ready
// and result valid/ready.
interface mix_columns_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/mix_columns_serial.sv
// Forward AES MixColumns, one 32-bit column per clock over four cycles.
// The result is held in a register until downstream accepts it.
module mix_columns_serial (
    input  logic                  clk,
    input  logic                  rst_n,
    mix_columns_serial_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] in_q, in_d;
    logic [127:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  col_in, col_out;
    logic         in_ready;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    assign in_ready      = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.state_out = out_q;

    // Column order is MSB first: cnt 0 works on bits [127:96].
    always_comb begin
        col_in = in_q[127:96];
        case (cnt_q)
            2'd0: col_in = in_q[127:96];
            2'd1: col_in = in_q[95:64];
            2'd2: col_in = in_q[63:32];
            2'd3: col_in = in_q[31:0];
            default: col_in = in_q[127:96];
        endcase
    end

    // The only instance of the column datapath.
    assign col_out = mix_col(col_in);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_d        = in_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    in_d    = bus.state_in;
                    cnt_d   = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                case (cnt_q)
                    2'd0: out_d[127:96] = col_out;
                    2'd1: out_d[95:64]  = col_out;
                    2'd2: out_d[63:32]  = col_out;
                    2'd3: out_d[31:0]   = col_out;
                    default: out_d      = out_q;
                endcase
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                // Without out_ready the held result is frozen and in_valid is ignored.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (bus.in_valid) begin
                        in_d    = bus.state_in;
                        cnt_d   = 2'd0;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            in_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_q        <= in_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mix_columns_serial.sv
// Self-checking bench for mix_columns_serial: directed FIPS/identity vectors,
// reset abort, backpressure, streaming and a randomized inverse cross-check.
module tb_mix_columns_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mix_columns_serial_if bus ();

    mix_columns_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Generic GF(2^8) multiply (shift-and-add, AES polynomial).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // Matrix multiply of every column by a circulant row (c0 c1 c2 c3).
    function automatic logic [127:0] circ(input logic [127:0] s,
                                          input logic [7:0] c0, input logic [7:0] c1,
                                          input logic [7:0] c2, input logic [7:0] c3);
        logic [127:0] r = '0;
        logic [7:0] a [4];
        logic [7:0] m [4];
        logic [7:0] acc;
        m[0] = c0; m[1] = c1; m[2] = c2; m[3] = c3;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[c*32 + 24 - 8*k +: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc ^= gmul(m[(k - row + 4) % 4], a[k]);
                r[c*32 + 24 - 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s);
        return circ(s, 8'h02, 8'h03, 8'h01, 8'h01);
    endfunction

    function automatic logic [127:0] inv_mix_model(input logic [127:0] s);
        return circ(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offers one state with out_ready=1, returns latency in edges and the result.
    task automatic run_one(input logic [127:0] s, output int lat, output logic [127:0] res);
        int n = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.state_in  = s;
        bus.out_ready = 1'b1;
        #1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        res = bus.state_out;
    endtask

    task automatic test_reset();
        int lat;
        logic [127:0] res;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.state_out !== 128'h0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_initial: out_valid=%b state_out=%h in_ready=%b, want 0/0/1",
                     bus.out_valid, bus.state_out, bus.in_ready);
        end
        // Start a block, abort it two edges into CALC.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.state_in = rand128(); bus.out_ready = 1'b1;
        @(negedge clk); bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.state_out !== 128'h0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_abort: out_valid=%b state_out=%h in_ready=%b, want 0/0/1",
                     bus.out_valid, bus.state_out, bus.in_ready);
        end
        run_one(128'hdb135345f20a225c01010101c6c6c6c6, lat, res);
        n_tests++;
        if (res !== mix_model(128'hdb135345f20a225c01010101c6c6c6c6) || lat != 4) begin
            n_fail++;
            $display("FAIL reset_after_block: got %h lat %0d, want %h lat 4",
                     res, lat, mix_model(128'hdb135345f20a225c01010101c6c6c6c6));
        end
    endtask

    task automatic test_fips();
        int lat;
        logic [127:0] res;
        run_one(128'hd4bf5d30e0b452aeb84111f11e2798e5, lat, res);
        n_tests++;
        if (res !== 128'h046681e5e0cb199a48f8d37a2806264c) begin
            n_fail++;
            $display("FAIL fips_result: got %h want 046681e5e0cb199a48f8d37a2806264c", res);
        end
        n_tests++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL fips_latency: got %0d want 4", lat);
        end
    endtask

    task automatic test_identities();
        int lat;
        logic [127:0] res;
        run_one(128'hdb135345f20a225c01010101c6c6c6c6, lat, res);
        n_tests++;
        if (res !== 128'h8e4da1bc9fdc589d01010101c6c6c6c6) begin
            n_fail++;
            $display("FAIL ident_a: got %h want 8e4da1bc9fdc589d01010101c6c6c6c6", res);
        end
        run_one(128'hd4d4d4d52d26314c0000000000000000, lat, res);
        n_tests++;
        if (res !== 128'hd5d5d7d64d7ebdf80000000000000000) begin
            n_fail++;
            $display("FAIL ident_b: got %h want d5d5d7d64d7ebdf80000000000000000", res);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] sa, sb;
        int n = 0;
        int lat = 0;
        int bad = 0;
        sa = rand128();
        sb = rand128();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.state_in = sa; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.state_in = sb;
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.state_out !== mix_model(sa)) begin
            n_fail++;
            $display("FAIL bp_first: out_valid=%b got %h want %h", bus.out_valid, bus.state_out, mix_model(sa));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.state_out !== mix_model(sa) || bus.in_ready !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        end
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        n_tests++;
        if (bus.state_out !== mix_model(sb) || lat != 4) begin
            n_fail++;
            $display("FAIL bp_second: got %h lat %0d, want %h lat 4", bus.state_out, lat, mix_model(sb));
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vec [5];
        int idx = 0;
        int oidx = 0;
        int cyc = 0;
        int last = 0;
        vec[0] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        vec[1] = 128'hdb135345f20a225c01010101c6c6c6c6;
        vec[2] = 128'hd4d4d4d52d26314c0000000000000000;
        vec[3] = rand128();
        vec[4] = rand128();
        bus.out_ready = 1'b1;
        while (oidx < 5 && cyc < 200) begin
            @(negedge clk);
            bus.in_valid = (idx < 5);
            bus.state_in = (idx < 5) ? vec[idx] : 128'h0;
            #1;
            if (bus.out_valid) begin
                n_tests++;
                if (bus.state_out !== mix_model(vec[oidx])) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got %h want %h", oidx, bus.state_out, mix_model(vec[oidx]));
                end
                if (oidx > 0) begin
                    n_tests++;
                    if (cyc - last != 5) begin
                        n_fail++;
                        $display("FAIL b2b_spacing[%0d]: got %0d want 5", oidx, cyc - last);
                    end
                end
                last = cyc;
                oidx++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            cyc++;
        end
        n_tests++;
        if (oidx != 5 || idx != 5) begin
            n_fail++;
            $display("FAIL b2b_count: accepted %0d delivered %0d want 5/5", idx, oidx);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] pend [$];
        logic [127:0] want, cur, held;
        int acc = 0;
        int got = 0;
        int cyc = 0;
        bit was_held = 0;
        cur = rand128();
        while (got < 1000 && cyc < 20000) begin
            @(negedge clk);
            bus.in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
            bus.state_in  = cur;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (was_held) begin
                n_tests++;
                if (bus.out_valid !== 1'b1 || bus.state_out !== held) begin
                    n_fail++;
                    $display("FAIL rand_stable: out_valid=%b got %h want %h", bus.out_valid, bus.state_out, held);
                end
            end
            was_held = bus.out_valid && !bus.out_ready;
            held = bus.state_out;
            if (bus.out_valid && bus.out_ready) begin
                n_tests++;
                if (pend.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious: output %h with nothing pending", bus.state_out);
                end else begin
                    want = pend.pop_front();
                    if (bus.state_out !== mix_model(want) || inv_mix_model(bus.state_out) !== want) begin
                        n_fail++;
                        $display("FAIL rand_block[%0d]: got %h want %h (src %h)", got, bus.state_out, mix_model(want), want);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                pend.push_back(cur);
                acc++;
                cur = rand128();
            end
            cyc++;
        end
        n_tests++;
        if (got != 1000 || pend.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: delivered %0d pending %0d want 1000/0", got, pend.size());
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.state_in  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.state_out !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_held: out_valid=%b state_out=%h want 0/0", bus.out_valid, bus.state_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_fips();
        test_identities();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
